// File: rtl/regfile_pkg.sv
// Shared types and constants for the MIPS register-file write side.
package regfile_pkg;
  localparam int         NUM_GPRS = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_LINK = 5'd31;
  localparam int         QDEPTH   = 2;

  typedef struct packed {
    logic        valid;
    logic [4:0]  dest;
    logic [31:0] data;
  } wr_req_t;
endpackage

// File: rtl/wb_write_decoder.sv
// Destination decoder: 5-bit dest plus enable to a one-hot GPR load enable.
// R0 is never loaded, so its enable bit is always forced low.
module wb_write_decoder
  import regfile_pkg::*;
(
  input  logic                en,
  input  logic [4:0]          dest,
  output logic [NUM_GPRS-1:0] load_en
);
  always_comb begin
    load_en = '0;
    if (en) load_en[dest] = 1'b1;
    load_en[REG_ZERO] = 1'b0;
  end
endmodule

// File: rtl/regfile_writer.sv
// MIPS GPR/HI/LO write side with a 2-entry deferred queue for late secondary writes.
// Define REGFILE_BYPASS_EN for same-cycle write-before-read on regs_flat/hi/lo.
module regfile_writer
  import regfile_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pri_we,
  input  logic [4:0]             pri_dest,
  input  logic [31:0]            pri_data,
  input  logic                   sec_valid,
  output logic                   sec_ready,
  input  logic [4:0]             sec_dest,
  input  logic [31:0]            sec_data,
  input  logic                   hi_we,
  input  logic                   lo_we,
  input  logic [31:0]            hi_wdata,
  input  logic [31:0]            lo_wdata,
  output logic [32*NUM_GPRS-1:0] regs_flat,
  output logic [31:0]            hi,
  output logic [31:0]            lo,
  output logic [1:0]             q_count
);
  wr_req_t pri, sec, wr;
  wr_req_t q     [QDEPTH];
  wr_req_t q_nxt [QDEPTH];
  logic [NUM_GPRS-1:0][31:0] gpr;
  logic [NUM_GPRS-1:0]       load_en;
  logic [31:0]               hi_q, lo_q;
  logic                      sec_fire, sec_keep, drain, direct;
  int                        fill;

  assign pri = '{valid: pri_we, dest: pri_dest, data: pri_data};
  assign sec = '{valid: 1'b1, dest: sec_dest, data: sec_data};

  // Queue is kept compacted toward entry 0, so the last slot marks "full".
  assign sec_ready = !q[QDEPTH-1].valid;
  assign sec_fire  = sec_valid && sec_ready;
  // Primary is younger: a same-dest secondary in the same cycle is dead on arrival.
  assign sec_keep  = sec_fire && (sec_dest != REG_ZERO) && !(pri_we && sec_dest == pri_dest);
  assign drain     = !pri_we && q[0].valid;
  assign direct    = sec_keep && !pri_we && !q[0].valid;

  always_comb begin
    wr = '0;
    if (pri_we)      wr = pri;
    else if (drain)  wr = q[0];
    else if (direct) wr = sec;
  end

  wb_write_decoder u_dec (.en(wr.valid), .dest(wr.dest), .load_en(load_en));

  // Survivors (not drained, not killed by a primary to the same dest) shift
  // down in order, then a deferred secondary lands at the first free slot.
  always_comb begin
    for (int j = 0; j < QDEPTH; j++) q_nxt[j] = '0;
    fill = 0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (q[i].valid && !(drain && i == 0) && !(pri_we && q[i].dest == pri_dest)) begin
        for (int j = 0; j < QDEPTH; j++)
          if (j == fill) q_nxt[j] = q[i];
        fill = fill + 1;
      end
    end
    if (sec_keep && !direct)
      for (int j = 0; j < QDEPTH; j++)
        if (j == fill) q_nxt[j] = sec;
  end

  always_comb begin
    q_count = '0;
    for (int i = 0; i < QDEPTH; i++) q_count = q_count + {1'b0, q[i].valid};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpr  <= '0;
      hi_q <= '0;
      lo_q <= '0;
      for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_GPRS; i++)
        if (load_en[i]) gpr[i] <= wr.data;
      for (int i = 0; i < QDEPTH; i++) q[i] <= q_nxt[i];
      if (hi_we) hi_q <= hi_wdata;
      if (lo_we) lo_q <= lo_wdata;
    end
  end

  for (genvar i = 0; i < NUM_GPRS; i++) begin : g_flat
`ifdef REGFILE_BYPASS_EN
    assign regs_flat[32*i +: 32] =
      (i != 0 && pri_we && pri_dest == 5'(i)) ? pri_data : gpr[i];
`else
    assign regs_flat[32*i +: 32] = gpr[i];
`endif
  end

`ifdef REGFILE_BYPASS_EN
  assign hi = hi_we ? hi_wdata : hi_q;
  assign lo = lo_we ? lo_wdata : lo_q;
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif
endmodule

// File: tb/tb_regfile_writer.sv
// Scoreboarded bench for regfile_writer: expected register values are queued
// when stimulus is driven and compared after the capturing edge.
module tb_regfile_writer;
  logic          clk = 1'b0;
  logic          reset_n;
  logic          pri_we, sec_valid, sec_ready, hi_we, lo_we;
  logic [4:0]    pri_dest, sec_dest;
  logic [31:0]   pri_data, sec_data, hi_wdata, lo_wdata, hi, lo;
  logic [1023:0] regs_flat;
  logic [1:0]    q_count;

  typedef struct {
    string       tag;
    int          dest;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  regfile_writer dut (
    .clk(clk), .reset_n(reset_n),
    .pri_we(pri_we), .pri_dest(pri_dest), .pri_data(pri_data),
    .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_dest(sec_dest), .sec_data(sec_data),
    .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .regs_flat(regs_flat), .hi(hi), .lo(lo), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int i);
    return regs_flat[32*i +: 32];
  endfunction

  task automatic expect_reg(input string tag, input int d, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.dest = d; e.val = v;
    sb.push_back(e);
  endtask

  task automatic score();
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      chk(e.tag, rd(e.dest), e.val);
    end
  endtask

  task automatic idle();
    pri_we = 0; pri_dest = '0; pri_data = '0;
    sec_valid = 0; sec_dest = '0; sec_data = '0;
    hi_we = 0; lo_we = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_pri(input int d, input logic [31:0] v);
    pri_we = 1; pri_dest = 5'(d); pri_data = v;
  endtask

  task automatic drive_sec(input int d, input logic [31:0] v);
    sec_valid = 1; sec_dest = 5'(d); sec_data = v;
  endtask

  initial begin
    logic [1023:0] t;
    int acc;
    idle(); hi_wdata = '0; lo_wdata = '0;
    reset_n = 0;
    repeat (2) cyc();
    chk("rst_qcnt", 32'(q_count), 0);
    chk("rst_ready", 32'(sec_ready), 1);
    chk("rst_flat", 32'(|regs_flat), 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset_n = 1;
    cyc();

    // basic primary write, then a write to R0 that must vanish
    drive_pri(5, 32'hDEADBEEF); expect_reg("r5", 5, 32'hDEADBEEF);
    cyc(); score();
    t = regs_flat; t[32*5 +: 32] = '0;
    chk("others_zero", 32'(|t), 0);
    drive_pri(0, 32'h1234); expect_reg("r0", 0, 0);
    cyc(); score();

`ifdef REGFILE_BYPASS_EN
    drive_pri(4, 32'h55); #1;
    chk("bypass_r4", rd(4), 32'h55);
    cyc();
`endif

    // direct secondary write with empty queue
    idle(); drive_sec(8, 32'h11);
    chk("t2_ready", 32'(sec_ready), 1);
    expect_reg("r8", 8, 32'h11);
    cyc(); score();
    chk("t2_qcnt", 32'(q_count), 0);

    // collision: primary first, secondary one cycle later
    idle(); drive_pri(3, 32'h33); drive_sec(9, 32'h22);
    expect_reg("r3", 3, 32'h33); expect_reg("r9_pend", 9, 0);
    cyc(); score();
    chk("t3_qcnt1", 32'(q_count), 1);
    idle(); expect_reg("r9", 9, 32'h22);
    cyc(); score();
    chk("t3_qcnt0", 32'(q_count), 0);

    // primary stream fills the queue; third secondary back-pressured
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      drive_pri(10 + c, 32'(32'hC0 + c));
      drive_sec(20 + acc, 32'(32'hA0 + acc));
      chk($sformatf("t4_ready%0d", c), 32'(sec_ready), 32'(c < 2));
      if (sec_ready) acc++;
      expect_reg($sformatf("t4_r%0d", 10 + c), 10 + c, 32'(32'hC0 + c));
      cyc(); score();
    end
    chk("t4_acc", 32'(acc), 2);
    chk("t4_qcnt2", 32'(q_count), 2);
    expect_reg("t4_r20_pend", 20, 0);
    score();
    pri_we = 0; drive_sec(22, 32'hA2);
    chk("t4_ready_full", 32'(sec_ready), 0);
    expect_reg("t4_r20", 20, 32'hA0); expect_reg("t4_r21_pend", 21, 0);
    cyc(); score();
    chk("t4_qcnt_a", 32'(q_count), 1);
    chk("t4_ready_room", 32'(sec_ready), 1);
    expect_reg("t4_r21", 21, 32'hA1); expect_reg("t4_r22_pend", 22, 0);
    cyc(); score();
    chk("t4_qcnt_b", 32'(q_count), 1);
    idle(); expect_reg("t4_r22", 22, 32'hA2);
    cyc(); score();
    chk("t4_qcnt_c", 32'(q_count), 0);

    // younger primary invalidates queued entry
    drive_pri(1, 32'h1); drive_sec(7, 32'hAA);
    cyc();
    chk("t5_qcnt1", 32'(q_count), 1);
    idle(); drive_pri(7, 32'hBB); expect_reg("t5_r7", 7, 32'hBB);
    cyc(); score();
    chk("t5_qcnt0", 32'(q_count), 0);
    idle(); expect_reg("t5_r7_hold", 7, 32'hBB);
    cyc(); score();

    // same-cycle same-dest secondary discarded
    drive_pri(6, 32'h66); drive_sec(6, 32'h77); expect_reg("t6_r6", 6, 32'h66);
    cyc(); score();
    chk("t6_qcnt", 32'(q_count), 0);
    idle(); expect_reg("t6_r6_hold", 6, 32'h66);
    cyc(); score();

    // two queued writes to one dest retire in order
    drive_pri(1, 32'h2); drive_sec(14, 32'hE1); cyc();
    drive_pri(2, 32'h3); drive_sec(14, 32'hE2); cyc();
    chk("t7_qcnt2", 32'(q_count), 2);
    idle(); expect_reg("t7_r14_a", 14, 32'hE1);
    cyc(); score();
    chk("t7_qcnt1", 32'(q_count), 1);
    expect_reg("t7_r14_b", 14, 32'hE2);
    cyc(); score();
    chk("t7_qcnt0", 32'(q_count), 0);

    // HI/LO alongside a GPR write, then HI alone
    drive_pri(31, 32'h31); hi_we = 1; hi_wdata = 32'h4811; lo_we = 1; lo_wdata = 32'h1011;
    expect_reg("t8_r31", 31, 32'h31);
    cyc(); score();
    chk("t8_hi", hi, 32'h4811);
    chk("t8_lo", lo, 32'h1011);
    idle(); hi_we = 1; hi_wdata = 32'h4822;
    cyc();
    chk("t8_hi2", hi, 32'h4822);
    chk("t8_lo_hold", lo, 32'h1011);

    // secondary to R0 accepted and dropped
    idle(); drive_sec(0, 32'h99); expect_reg("t9_r0", 0, 0);
    cyc(); score();
    chk("t9_qcnt", 32'(q_count), 0);

    // asynchronous reset with a full queue
    idle(); drive_pri(1, 32'h5); drive_sec(15, 32'hF5); cyc();
    drive_pri(2, 32'h6); drive_sec(16, 32'hF6); cyc();
    chk("t10_qcnt2", 32'(q_count), 2);
    idle(); #2 reset_n = 0; #1;
    chk("t10_qcnt", 32'(q_count), 0);
    chk("t10_ready", 32'(sec_ready), 1);
    chk("t10_flat", 32'(|regs_flat), 0);
    chk("t10_hi", hi, 0);
    chk("t10_lo", lo, 0);
    cyc(); reset_n = 1;
    cyc(); cyc();
    expect_reg("t10_r15_lost", 15, 0); expect_reg("t10_r16_lost", 16, 0);
    score();
    chk("t10_qcnt_after", 32'(q_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
